// File: rtl/dest_reader_if.sv
// Handshake bundle between dest_reader, the two destination FIFOs and the downstream consumer.
interface dest_reader_if #(parameter int BW = 6);
   logic          D0_empty;
   logic          D1_empty;
   logic [BW-1:0] D0_data_out;
   logic [BW-1:0] D1_data_out;
   logic          D0_rd;
   logic          D1_rd;
   logic          out_valid;
   logic          out_ready;
   logic [BW-1:0] out_data;
   logic          out_dest;

   modport master (
      output D0_empty, D1_empty, D0_data_out, D1_data_out, out_ready,
      input  D0_rd, D1_rd, out_valid, out_data, out_dest
   );

   modport slave (
      input  D0_empty, D1_empty, D0_data_out, D1_data_out, out_ready,
      output D0_rd, D1_rd, out_valid, out_data, out_dest
   );
endinterface

// File: rtl/dest_reader.sv
// Round-robin reader for two destination FIFOs feeding a 2-entry output buffer.
// Reads return one cycle after the pop; the buffer never overflows because reads in flight are reserved space.
module dest_reader #(
   parameter int BW = 6
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic       enable,
   dest_reader_if.slave bus,
   output logic [7:0] cnt_D0,
   output logic [7:0] cnt_D1,
   output logic       busy
);

   localparam logic [1:0] IDLE    = 2'b00;
   localparam logic [1:0] READING = 2'b01;
   localparam logic [1:0] HOLD    = 2'b10;

   logic [BW:0] mem_r [2];
   logic        wr_ptr_r;
   logic        rd_ptr_r;
   logic [1:0]  count_r;
   logic        inflight_r;
   logic        inflight_dest_r;
   logic        rr_r;
   logic [1:0]  state_r;
   logic [7:0]  cnt_d0_r;
   logic [7:0]  cnt_d1_r;

   logic        out_valid_s;
   logic        pop_s;
   logic [2:0]  occ_s;
   logic        has_space_s;
   logic        sel_s;
   logic        issue_s;
   logic [1:0]  count_next_s;
   logic [BW:0] wr_entry_s;
   logic [BW:0] head_s;
   logic [1:0]  state_next_s;

   assign out_valid_s  = (count_r != 2'd0);
   assign pop_s        = out_valid_s & bus.out_ready;
   // Space is judged after this cycle's pop so a steady stream can sustain one read per cycle.
   assign occ_s        = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
   assign has_space_s  = (occ_s < 3'd2);
   assign count_next_s = count_r + {1'b0, inflight_r} - {1'b0, pop_s};
   assign wr_entry_s   = {inflight_dest_r, (inflight_dest_r ? bus.D1_data_out : bus.D0_data_out)};
   assign head_s       = mem_r[rd_ptr_r];

   assign bus.D0_rd     = issue_s & ~sel_s;
   assign bus.D1_rd     = issue_s & sel_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_data  = out_valid_s ? head_s[BW-1:0] : {BW{1'b0}};
   assign bus.out_dest  = out_valid_s ? head_s[BW] : 1'b0;
   assign cnt_D0        = cnt_d0_r;
   assign cnt_D1        = cnt_d1_r;
   assign busy          = (state_r != IDLE);

   // Arbitration: pick the FIFO to read and decide whether a read may issue.
   always_comb begin
      sel_s   = rr_r;
      issue_s = 1'b0;
      if (!bus.D0_empty && !bus.D1_empty) begin
         sel_s = rr_r;
      end else if (!bus.D0_empty) begin
         sel_s = 1'b0;
      end else begin
         sel_s = 1'b1;
      end
      if (reset_L && enable && has_space_s && (!bus.D0_empty || !bus.D1_empty)) begin
         issue_s = 1'b1;
      end else begin
         issue_s = 1'b0;
      end
   end

   // Next FSM state from the post-issue, post-return view of the datapath.
   always_comb begin
      state_next_s = IDLE;
      if (issue_s) begin
         state_next_s = READING;
      end else if (count_next_s != 2'd0) begin
         state_next_s = HOLD;
      end else begin
         state_next_s = IDLE;
      end
   end

   // Output buffer storage and pointers.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int i = 0; i < 2; i++) begin
            mem_r[i] <= {(BW+1){1'b0}};
         end
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (inflight_r) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         count_r <= count_next_s;
      end
   end

   // In-flight read tracking and round-robin pointer.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         inflight_r      <= 1'b0;
         inflight_dest_r <= 1'b0;
         rr_r            <= 1'b0;
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            inflight_dest_r <= sel_s;
            rr_r            <= ~sel_s;
         end
      end
   end

   // Delivered-word counters, wrapping modulo 256.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         cnt_d0_r <= 8'd0;
         cnt_d1_r <= 8'd0;
      end else if (pop_s) begin
         if (head_s[BW]) begin
            cnt_d1_r <= cnt_d1_r + 8'd1;
         end else begin
            cnt_d0_r <= cnt_d0_r + 8'd1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

endmodule

// File: tb/tb_dest_reader.sv
// Randomized bench for dest_reader: FIFO environment, queue-based reference model and output scoreboard.
module tb_dest_reader;
   localparam int BW = 6;

   logic       clk = 1'b0;
   logic       reset_L;
   logic       enable;
   logic [7:0] cnt_D0;
   logic [7:0] cnt_D1;
   logic       busy;

   dest_reader_if #(.BW(BW)) bus();

   dest_reader #(.BW(BW)) dut (
      .clk(clk), .reset_L(reset_L), .enable(enable), .bus(bus),
      .cnt_D0(cnt_D0), .cnt_D1(cnt_D1), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          dest;
      logic [BW-1:0] data;
      int            ready_at;
   } word_t;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   logic [BW-1:0] q0[$];
   logic [BW-1:0] q1[$];
   word_t         mq[$];
   logic [BW:0]   sb_q[$];
   bit            m_rr;
   int            m_cnt0;
   int            m_cnt1;
   bit            prev_hold;
   logic [BW:0]   prev_word;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endfunction

   // Destination FIFO environment: pop on rd, data valid the following cycle.
   always @(posedge clk) begin
      if (bus.D0_rd && q0.size() > 0) begin
         bus.D0_data_out <= q0[0];
         q0.delete(0);
      end
      if (bus.D1_rd && q1.size() > 0) begin
         bus.D1_data_out <= q1[0];
         q1.delete(0);
      end
   end

   // Reference model: at most two words outstanding, each visible two cycles after its read.
   always @(negedge clk) begin : model
      bit    exp_valid, pop, any, both, sel;
      int    outstanding;
      word_t w;
      cyc++;
      if (!reset_L) begin
         check("reset_outputs",
               {bus.D0_rd, bus.D1_rd, bus.out_valid, busy, bus.out_dest, bus.out_data, cnt_D0, cnt_D1},
               32'd0);
         mq.delete();
         sb_q.delete();
         m_rr   = 1'b0;
         m_cnt0 = 0;
         m_cnt1 = 0;
      end else begin
         exp_valid = (mq.size() > 0) && (mq[0].ready_at <= cyc);
         check("out_valid", bus.out_valid, exp_valid);
         check("busy", busy, mq.size() != 0);
         check("cnt_D0", cnt_D0, m_cnt0 % 256);
         check("cnt_D1", cnt_D1, m_cnt1 % 256);
         pop         = exp_valid && bus.out_ready;
         outstanding = mq.size() - (pop ? 1 : 0);
         any  = enable && (!bus.D0_empty || !bus.D1_empty) && (outstanding < 2);
         both = !bus.D0_empty && !bus.D1_empty;
         sel  = both ? m_rr : bus.D0_empty;
         check("rd", {bus.D1_rd, bus.D0_rd}, any ? (sel ? 2'b10 : 2'b01) : 2'b00);
         if (pop) begin
            if (mq[0].dest) m_cnt1++;
            else m_cnt0++;
            mq.delete(0);
         end
         if (any) begin
            w.dest     = sel;
            w.data     = sel ? q1[0] : q0[0];
            w.ready_at = cyc + 2;
            mq.push_back(w);
            sb_q.push_back({w.dest, w.data});
            m_rr = !sel;
         end
      end
   end

   // Monitor: every accepted word must match the scoreboard head; held words must not change.
   always @(negedge clk) begin
      if (reset_L) begin
         if (prev_hold && bus.out_valid) begin
            check("hold_stable", {bus.out_dest, bus.out_data}, prev_word);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               check("out_word", {bus.out_dest, bus.out_data}, sb_q[0]);
               sb_q.delete(0);
            end
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_word = {bus.out_dest, bus.out_data};
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic step(input bit en, input bit rdy, input int p0, input int p1);
      @(posedge clk);
      #1;
      enable        = en;
      bus.out_ready = rdy;
      for (int i = 0; i < p0; i++) q0.push_back(BW'($urandom));
      for (int i = 0; i < p1; i++) q1.push_back(BW'($urandom));
      bus.D0_empty = (q0.size() == 0);
      bus.D1_empty = (q1.size() == 0);
   endtask

   initial begin
      reset_L         = 1'b0;
      enable          = 1'b0;
      bus.out_ready   = 1'b0;
      bus.D0_empty    = 1'b1;
      bus.D1_empty    = 1'b1;
      bus.D0_data_out = '0;
      bus.D1_data_out = '0;
      prev_hold       = 1'b0;
      prev_word       = '0;
      repeat (3) step(1'b0, 1'b0, 0, 0);
      reset_L = 1'b1;

      // both FIFOs loaded: alternating reads
      step(1'b1, 1'b1, 8, 8);
      repeat (30) step(1'b1, 1'b1, 0, 0);
      // only D1 with three words
      step(1'b1, 1'b1, 0, 3);
      repeat (8) step(1'b1, 1'b1, 0, 0);
      // backpressure then release
      step(1'b1, 1'b0, 6, 6);
      repeat (10) step(1'b1, 1'b0, 0, 0);
      repeat (30) step(1'b1, 1'b1, 0, 0);
      // enough D0 words to wrap cnt_D0
      step(1'b1, 1'b1, 260, 0);
      repeat (280) step(1'b1, 1'b1, 0, 0);
      // enable dropped right after a read
      step(1'b1, 1'b1, 2, 0);
      repeat (6) step(1'b0, 1'b1, 0, 0);
      // reset while the buffer is full
      step(1'b1, 1'b0, 3, 3);
      repeat (5) step(1'b1, 1'b0, 0, 0);
      reset_L = 1'b0;
      repeat (2) step(1'b1, 1'b0, 0, 0);
      reset_L = 1'b1;
      repeat (10) step(1'b1, 1'b1, 0, 0);
      // random traffic
      repeat (3000) begin
         step(($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0),
              ((q0.size() < 6) && ($urandom_range(1, 0) == 1)) ? 1 : 0,
              ((q1.size() < 6) && ($urandom_range(1, 0) == 1)) ? 1 : 0);
      end
      repeat (30) step(1'b1, 1'b1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
